bullet_hit_scanner: RTL and testbench

//  Sits directly downstream of the bullet store, on its collision/damage read port.
//  On every frame tick it walks the bullet slots one per cycle and tests each rendered bullet's box against the player box.
//  It pulses is_collide so the store can retire a bullet that hit, and it keeps player HP, the invulnerability window and the dead flag.

---
 rtl/bullet_hit_scanner.sv | 165 ++++++++++++++++
 tb/tb_bullet_hit_scanner.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner
// Collision/damage scanner that sits on the bullet store's second read port.
// Each frame tick walks the bullet slots one per cycle, tests each live
// bullet's box against the player box, pulses is_collide so the store can
// retire the bullet, and tracks player HP, invulnerability and death.
//
// Read-port protocol with the bullet store: index2 is a registered slot
// address; the store answers combinationally on position2/size2/color2/
// is_render2 within the same cycle. There is no ready/valid back-pressure:
// is_collide is a one-cycle pulse that always refers to the slot index2 held
// in the previous cycle, and the store must act on it in that cycle.
module bullet_hit_scanner #(
    parameter int NUM_BULLETS  = 3,
    parameter int HP_MAX       = 20,
    parameter int DAMAGE       = 4,
    parameter int HEAL         = 2,
    parameter int INVULN_TICKS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_run,
    input  logic        frame_tick,
    input  logic [15:0] player_pos,
    input  logic [15:0] player_size,
    input  logic        player_moving,
    output logic [2:0]  index2,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [1:0]  color2,
    input  logic        is_render2,
    output logic        is_collide,
    output logic [7:0]  hp,
    output logic        invuln,
    output logic        dead,
    output logic        scan_busy,
    output logic [1:0]  scan_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int              CW       = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_BULLETS - 1);
    localparam logic [7:0]      HP_FULL  = 8'(HP_MAX);
    localparam logic [7:0]      DMG_V    = 8'(DAMAGE);
    localparam logic [8:0]      HEAL_V   = 9'(HEAL);
    localparam logic [8:0]      HP_FULL9 = 9'(HP_MAX);
    localparam logic [CW-1:0]   INV_LOAD = CW'(INVULN_TICKS);

    state_t        state;
    logic [CW-1:0] inv_cnt;

    // Box edges widened to 9 bits so right/bottom edges never wrap.
    logic [8:0] px, py, pw, ph;
    logic [8:0] bx, by, bw, bh;
    logic [8:0] p_right, p_bottom, b_right, b_bottom;

    assign px = {1'b0, player_pos[15:8]};
    assign py = {1'b0, player_pos[7:0]};
    assign pw = {1'b0, player_size[15:8]};
    assign ph = {1'b0, player_size[7:0]};
    assign bx = {1'b0, position2[15:8]};
    assign by = {1'b0, position2[7:0]};
    assign bw = {1'b0, size2[15:8]};
    assign bh = {1'b0, size2[7:0]};

    assign p_right  = px + pw;
    assign p_bottom = py + ph;
    assign b_right  = bx + bw;
    assign b_bottom = by + bh;

    logic nonzero_boxes;
    logic overlap;
    logic live_hit;
    logic dmg_color;
    logic dmg_hit;
    logic heal_hit;

    // A zero width or height box has no area, so it can never overlap even
    // though the strict edge compares alone could still be satisfied.
    assign nonzero_boxes = (pw != 9'd0) && (ph != 9'd0) && (bw != 9'd0) && (bh != 9'd0);
    assign overlap       = nonzero_boxes &&
                           (bx < p_right) && (px < b_right) &&
                           (by < p_bottom) && (py < b_bottom);

    // Hits only count during SCAN; once the player is dead nothing else lands,
    // so a later green slot in the same scan cannot bring the player back.
    assign live_hit  = (state == SCAN) && is_render2 && overlap && !dead;
    assign dmg_color = (color2 == 2'd0) || ((color2 == 2'd2) && player_moving);
    assign dmg_hit   = live_hit && dmg_color && !invuln;
    assign heal_hit  = live_hit && (color2 == 2'd1);

    logic [8:0] heal_sum;
    logic [7:0] hp_after_dmg;
    logic [7:0] hp_after_heal;

    assign heal_sum      = {1'b0, hp} + HEAL_V;
    assign hp_after_heal = (heal_sum >= HP_FULL9) ? HP_FULL : heal_sum[7:0];
    assign hp_after_dmg  = (hp <= DMG_V) ? 8'd0 : (hp - DMG_V);

    assign dead       = (hp == 8'd0);
    assign invuln     = (inv_cnt != '0);
    assign scan_state = state;

    // Scan sequencer: walks index2 across the slots, registers the hit pulse.
    always_ff @(posedge clk) begin
        if (rst || !is_run) begin
            state      <= IDLE;
            index2     <= 3'd0;
            is_collide <= 1'b0;
            scan_busy  <= 1'b0;
        end else begin
            is_collide <= dmg_hit || heal_hit;
            case (state)
                IDLE: begin
                    if (frame_tick && !dead) begin
                        state     <= SCAN;
                        index2    <= 3'd0;
                        scan_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (index2 == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        index2 <= index2 + 3'd1;
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

    // Player status: HP commits with the hit pulse, invulnerability counts frames.
    always_ff @(posedge clk) begin
        if (rst || !is_run) begin
            hp      <= HP_FULL;
            inv_cnt <= '0;
        end else begin
            if (dmg_hit) begin
                hp <= hp_after_dmg;
            end else if (heal_hit) begin
                hp <= hp_after_heal;
            end

            // A damage load on the same edge as a tick wins over the decrement.
            if (dmg_hit) begin
                inv_cnt <= INV_LOAD;
            end else if (frame_tick && invuln) begin
                inv_cnt <= inv_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Self-checking bench for bullet_hit_scanner: a bullet-store model answers
// the read port, and a frame-level reference model predicts pulses and HP.
module tb_bullet_hit_scanner;

    localparam int NB     = 3;
    localparam int HP_MAX = 20;
    localparam int DAMAGE = 4;
    localparam int HEAL   = 2;
    localparam int INV    = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_run;
    logic        frame_tick;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic        player_moving;
    logic [2:0]  index2;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [1:0]  color2;
    logic        is_render2;
    logic        is_collide;
    logic [7:0]  hp;
    logic        invuln;
    logic        dead;
    logic        scan_busy;
    logic [1:0]  scan_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_hp  = HP_MAX;
    int m_cnt = 0;
    logic [7:0] exp_q[$];

    // Bullet store contents
    logic [7:0] sx[NB];
    logic [7:0] sy[NB];
    logic [7:0] sw[NB];
    logic [7:0] sh[NB];
    logic [1:0] sc[NB];
    logic       sr[NB];

    // Clock and DUT
    always #5 clk = ~clk;

    bullet_hit_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .is_run       (is_run),
        .frame_tick   (frame_tick),
        .player_pos   (player_pos),
        .player_size  (player_size),
        .player_moving(player_moving),
        .index2       (index2),
        .position2    (position2),
        .size2        (size2),
        .color2       (color2),
        .is_render2   (is_render2),
        .is_collide   (is_collide),
        .hp           (hp),
        .invuln       (invuln),
        .dead         (dead),
        .scan_busy    (scan_busy),
        .scan_state   (scan_state)
    );

    // Bullet store read port: combinational answer to index2
    always_comb begin
        position2  = 16'h0;
        size2      = 16'h0;
        color2     = 2'd3;
        is_render2 = 1'b0;
        if (int'(index2) < NB) begin
            position2  = {sx[index2], sy[index2]};
            size2      = {sw[index2], sh[index2]};
            color2     = sc[index2];
            is_render2 = sr[index2];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                            input int c, input bit r);
        sx[i] = 8'(x);
        sy[i] = 8'(y);
        sw[i] = 8'(w);
        sh[i] = 8'(h);
        sc[i] = 2'(c);
        sr[i] = r;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NB; i++) set_slot(i, 0, 0, 0, 0, 3, 1'b0);
    endtask

    task automatic set_player(input int x, input int y, input int w, input int h);
        player_pos  = {8'(x), 8'(y)};
        player_size = {8'(w), 8'(h)};
    endtask

    // Reference: 0 = no hit, 1 = damaging, 2 = healing, from the game rules
    function automatic int slot_hit(input int i);
        int  px, py, pw, ph, bx, by, bw, bh;
        bit  ov;
        px = int'(player_pos[15:8]);
        py = int'(player_pos[7:0]);
        pw = int'(player_size[15:8]);
        ph = int'(player_size[7:0]);
        bx = int'(sx[i]);
        by = int'(sy[i]);
        bw = int'(sw[i]);
        bh = int'(sh[i]);
        ov = (pw > 0) && (ph > 0) && (bw > 0) && (bh > 0) &&
             (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
        if (!sr[i] || !ov || m_hp == 0) return 0;
        if (sc[i] == 2'd1) return 2;
        if ((sc[i] == 2'd0 || (sc[i] == 2'd2 && player_moving)) && m_cnt == 0) return 1;
        return 0;
    endfunction

    // One frame: tick, follow the scan, compare pulses and final status.
    // tick_slot >= 0 raises an extra tick during that slot's cycle.
    task automatic run_frame(input int tick_slot);
        logic [NB-1:0] exp_mask;
        logic [NB-1:0] obs_mask;
        int            kind;
        exp_mask = '0;
        obs_mask = '0;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        if (m_cnt > 0) m_cnt--;
        if (m_hp == 0) begin
            repeat (2) begin
                @(negedge clk);
                check("no_scan_dead", scan_busy, 0);
            end
            check("dead_hp", hp, 0);
            return;
        end
        for (int i = 0; i < NB; i++) begin
            if (tick_slot == i) frame_tick = 1'b1;
            @(negedge clk);
            check("index2", index2, i);
            check("busy_scan", scan_busy, 1);
            if (i == 0) check("no_pulse_first", is_collide, 0);
            else obs_mask[i-1] = is_collide;
            kind = slot_hit(i);
            exp_mask[i] = (kind != 0);
            if (kind == 1) begin
                m_hp  = (m_hp <= DAMAGE) ? 0 : m_hp - DAMAGE;
                m_cnt = INV;
            end else begin
                if (kind == 2) m_hp = (m_hp + HEAL > HP_MAX) ? HP_MAX : m_hp + HEAL;
                if (tick_slot == i && m_cnt > 0) m_cnt--;
            end
            @(posedge clk); #1 frame_tick = 1'b0;
        end
        @(negedge clk);
        obs_mask[NB-1] = is_collide;
        check("busy_drain", scan_busy, 1);
        check("index_hold", index2, NB - 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_done", scan_busy, 0);
        check("no_pulse_idle", is_collide, 0);
        check("pulse_mask", obs_mask, exp_mask);
        exp_q.push_back(8'(m_hp));
        check("hp", hp, exp_q.pop_front());
        check("invuln", invuln, (m_cnt != 0));
        check("dead", dead, (m_hp == 0));
    endtask

    task automatic run_pulse_low();
        @(posedge clk); #1 is_run = 1'b0;
        @(posedge clk); #1 is_run = 1'b1;
        m_hp  = HP_MAX;
        m_cnt = 0;
        @(negedge clk);
        check("revive_hp", hp, HP_MAX);
        check("revive_dead", dead, 0);
        check("revive_invuln", invuln, 0);
    endtask

    // Frames with nothing live until the model's invulnerability runs out
    task automatic wait_invuln_clear();
        logic [7:0] kx[NB];
        logic       kr[NB];
        for (int i = 0; i < NB; i++) begin
            kx[i] = sx[i];
            kr[i] = sr[i];
            sr[i] = 1'b0;
        end
        for (int n = 0; n < INV + 2 && m_cnt != 0; n++) run_frame(-1);
        for (int i = 0; i < NB; i++) begin
            sx[i] = kx[i];
            sr[i] = kr[i];
        end
    endtask

    initial begin
        rst           = 1'b1;
        is_run        = 1'b1;
        frame_tick    = 1'b0;
        player_moving = 1'b0;
        set_player(100, 100, 16, 16);
        clear_slots();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hp", hp, HP_MAX);
        check("rst_invuln", invuln, 0);
        check("rst_dead", dead, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_index2", index2, 0);
        check("rst_collide", is_collide, 0);
        check("rst_state", scan_state, 0);

        // Single white hit on slot 1
        set_slot(1, 108, 104, 8, 8, 0, 1'b1);
        run_frame(-1);
        check("t1_hp", hp, 16);
        check("t1_invuln", invuln, 1);

        // Invulnerability window: 29 suppressed frames, then damage again
        for (int n = 0; n < 29; n++) run_frame(-1);
        check("t2_hp_held", hp, 16);
        run_frame(-1);
        check("t2_hp", hp, 12);

        // Blue needs movement; green heals and saturates
        run_pulse_low();
        set_slot(1, 108, 104, 8, 8, 2, 1'b1);
        player_moving = 1'b0;
        run_frame(-1);
        player_moving = 1'b1;
        run_frame(-1);
        check("t3_blue_hp", hp, 16);
        set_slot(1, 108, 104, 8, 8, 1, 1'b1);
        run_frame(-1);
        run_frame(-1);
        run_frame(-1);
        check("t3_green_sat", hp, HP_MAX);
        player_moving = 1'b0;

        // Edges, 9-bit sums, zero size
        run_pulse_low();
        set_slot(1, 116, 104, 8, 8, 0, 1'b1);
        run_frame(-1);
        set_slot(1, 108, 116, 8, 8, 0, 1'b1);
        run_frame(-1);
        set_slot(1, 108, 104, 0, 8, 0, 1'b1);
        run_frame(-1);
        check("t4_no_hit_hp", hp, HP_MAX);
        set_slot(1, 200, 100, 255, 8, 0, 1'b1);
        set_player(150, 100, 16, 16);
        run_frame(-1);
        check("t4_wide_left", hp, HP_MAX);
        set_player(250, 100, 16, 16);
        run_frame(-1);
        check("t4_wide_wrap", hp, 16);

        // Death at hp <= DAMAGE, no scans afterwards, revive via is_run
        set_player(100, 100, 16, 16);
        set_slot(1, 108, 104, 8, 8, 0, 1'b1);
        while (m_hp > 0) begin
            wait_invuln_clear();
            run_frame(-1);
        end
        check("t5_dead", dead, 1);
        run_frame(-1);
        run_frame(-1);
        run_pulse_low();

        // Reset while a hit is in flight
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_hp  = HP_MAX;
        m_cnt = 0;
        @(negedge clk);
        check("t6_collide", is_collide, 0);
        check("t6_hp", hp, HP_MAX);
        check("t6_state", scan_state, 0);
        check("t6_busy", scan_busy, 0);

        // Tick mid-scan: ignored for scanning, load wins, decrement otherwise
        run_frame(1);
        run_frame(0);
        run_frame(2);

        // Randomized frames
        for (int f = 0; f < 200; f++) begin
            int px, py;
            set_player($urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 40), $urandom_range(0, 40));
            px = int'(player_pos[15:8]);
            py = int'(player_pos[7:0]);
            for (int i = 0; i < NB; i++) begin
                int bx, by, bw;
                bx = px + int'($urandom_range(0, 60)) - 20;
                by = py + int'($urandom_range(0, 60)) - 20;
                bx = (bx < 0) ? 0 : (bx > 255) ? 255 : bx;
                by = (by < 0) ? 0 : (by > 255) ? 255 : by;
                bw = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 30));
                set_slot(i, bx, by, bw, $urandom_range(0, 30), $urandom_range(0, 3),
                         ($urandom_range(0, 3) != 0));
            end
            player_moving = $urandom_range(0, 1);
            if ($urandom_range(0, 14) == 0 || m_hp == 0) run_pulse_low();
            run_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
